// File: rtl/add16_seq_arb_pkg.sv
// Shared constants for the nibble-serial adder: FSM state encoding and slice width.
package add16_seq_arb_pkg;

    localparam int NIB_W = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADD  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/abc_adder.sv
// Team 4-bit carry-look-ahead adder slice.
module abc_adder (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       CIN,
    output logic [3:0] S,
    output logic       COUT
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g = A & B;
    assign p = A ^ B;

    // Every carry is expanded directly from CIN, so none waits on a lower carry.
    assign c[0] = CIN;
    assign c[1] = g[0] | (p[0] & CIN);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & CIN);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & CIN);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & CIN);

    assign S    = p ^ c[3:0];
    assign COUT = c[4];

endmodule

// File: rtl/add16_seq_arb.sv
// Two-requester round-robin adder: one WIDTH-bit addition performed a nibble per cycle
// through a single 4-bit look-ahead slice.
module add16_seq_arb
    import add16_seq_arb_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic             cin0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    input  logic             cin1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             busy,
    output logic             done,
    output logic             done_id,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NIB  = WIDTH / NIB_W;
    localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIB - 1);

    logic [1:0]       state;
    logic [IDXW-1:0]  nib_idx;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic             carry_r;
    logic             id_r;
    logic             last_served;
    logic             grant;
    logic             pick1;
    logic [NIB_W-1:0] slice_a;
    logic [NIB_W-1:0] slice_b;
    logic [NIB_W-1:0] slice_s;
    logic             slice_co;

    // Grants are decided combinationally in IDLE; on a tie the requester not served last wins.
    assign grant = (state == ST_IDLE) && !rst && (req0 || req1);
    assign pick1 = req1 && (!req0 || !last_served);
    assign gnt0  = grant && !pick1;
    assign gnt1  = grant && pick1;

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);

    assign slice_a = a_r[nib_idx*NIB_W +: NIB_W];
    assign slice_b = b_r[nib_idx*NIB_W +: NIB_W];

    abc_adder u_slice (
        .A    (slice_a),
        .B    (slice_b),
        .CIN  (carry_r),
        .S    (slice_s),
        .COUT (slice_co)
    );

    always_comb begin
        acc_next = acc;
        acc_next[nib_idx*NIB_W +: NIB_W] = slice_s;
    end

    // carry_r is loaded with the requester's cin at grant, then carries nibble to nibble.
    // Results are written on the final ADD edge so they are already valid while done is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            nib_idx     <= '0;
            a_r         <= '0;
            b_r         <= '0;
            acc         <= '0;
            carry_r     <= 1'b0;
            id_r        <= 1'b0;
            last_served <= 1'b1;
            sum         <= '0;
            cout        <= 1'b0;
            ovf         <= 1'b0;
            done_id     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant) begin
                        a_r         <= pick1 ? a1 : a0;
                        b_r         <= pick1 ? b1 : b0;
                        carry_r     <= pick1 ? cin1 : cin0;
                        id_r        <= pick1;
                        last_served <= pick1;
                        nib_idx     <= '0;
                        acc         <= '0;
                        state       <= ST_ADD;
                    end
                end
                ST_ADD: begin
                    acc     <= acc_next;
                    carry_r <= slice_co;
                    nib_idx <= nib_idx + 1'b1;
                    if (nib_idx == LAST_IDX) begin
                        state   <= ST_DONE;
                        sum     <= acc_next;
                        cout    <= slice_co;
                        ovf     <= (a_r[WIDTH-1] == b_r[WIDTH-1]) && (acc_next[WIDTH-1] != a_r[WIDTH-1]);
                        done_id <= id_r;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_add16_seq_arb.sv
// Directed bench for add16_seq_arb: vector table plus reset and arbitration sequences.
module tb_add16_seq_arb;

    typedef struct {
        logic        id;
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] s;
        logic        co;
        logic        ov;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [15:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic        cin0 = 1'b0, cin1 = 1'b0;
    logic        gnt0, gnt1, busy, done, done_id, cout, ovf;
    logic [15:0] sum;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    add16_seq_arb #(.WIDTH(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .req0    (req0),
        .a0      (a0),
        .b0      (b0),
        .cin0    (cin0),
        .req1    (req1),
        .a1      (a1),
        .b1      (b1),
        .cin1    (cin1),
        .gnt0    (gnt0),
        .gnt1    (gnt1),
        .busy    (busy),
        .done    (done),
        .done_id (done_id),
        .sum     (sum),
        .cout    (cout),
        .ovf     (ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Grants must be exclusive and never appear while a transaction is in flight.
    always @(negedge clk) begin
        #2;
        if (!rst && (gnt0 || gnt1 || busy)) begin
            checkOutput("gnt_exclusive", {31'b0, gnt0 & gnt1}, 32'd0);
            checkOutput("gnt_while_busy", {31'b0, (gnt0 | gnt1) & busy}, 32'd0);
        end
    end

    task automatic applyStimulus(input vec_t v);
        int tg;
        int td;
        tg = -1;
        td = -1;
        @(negedge clk);
        if (v.id) begin
            req1 = 1'b1; a1 = v.a; b1 = v.b; cin1 = v.cin;
        end else begin
            req0 = 1'b1; a0 = v.a; b0 = v.b; cin0 = v.cin;
        end
        for (int i = 0; i < 20 && tg < 0; i++) begin
            #1;
            if (gnt0 || gnt1) begin
                tg = cyc;
                checkOutput("gnt_id", {31'b0, gnt1}, {31'b0, v.id});
            end else begin
                @(negedge clk);
            end
        end
        if (tg < 0) begin
            checkOutput("gnt_timeout", 32'd0, 32'd1);
            req0 = 1'b0;
            req1 = 1'b0;
            return;
        end
        // Scramble every operand after the grant; the result must not notice.
        @(negedge clk);
        req0 = 1'b0; req1 = 1'b0;
        a0 = 16'hDEAD; b0 = 16'hBEEF; cin0 = ~cin0;
        a1 = 16'h5A5A; b1 = 16'hA5A5; cin1 = ~cin1;
        for (int i = 0; i < 20 && td < 0; i++) begin
            #1;
            if (done) td = cyc;
            else @(negedge clk);
        end
        if (td < 0) begin
            checkOutput("done_timeout", 32'd0, 32'd1);
            return;
        end
        checkOutput("latency", td - tg, 32'd5);
        checkOutput("sum", {16'b0, sum}, {16'b0, v.s});
        checkOutput("cout", {31'b0, cout}, {31'b0, v.co});
        checkOutput("ovf", {31'b0, ovf}, {31'b0, v.ov});
        checkOutput("done_id", {31'b0, done_id}, {31'b0, v.id});
    endtask

    vec_t vecs[8];
    int   ids[4];
    int   gcyc[4];
    int   n;
    bit   done_seen;

    initial begin
        vecs[0] = '{1'b0, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 16'h000F, 16'h0000, 1'b1, 16'h0010, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[5] = '{1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 16'h4000, 16'h4000, 1'b0, 16'h8000, 1'b0, 1'b1};

        // Reset state, with a request pending that must not be granted.
        req0 = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("rst_no_gnt", {30'b0, gnt1, gnt0}, 32'd0);
        checkOutput("rst_busy", {31'b0, busy}, 32'd0);
        checkOutput("rst_done", {31'b0, done}, 32'd0);
        checkOutput("rst_sum", {16'b0, sum}, 32'd0);
        checkOutput("rst_flags", {29'b0, cout, ovf, done_id}, 32'd0);
        req0 = 1'b0;
        rst  = 1'b0;

        for (int i = 0; i < 8; i++) applyStimulus(vecs[i]);

        // Both requesters held from reset release: strict alternation every 6 cycles.
        @(negedge clk);
        rst = 1'b1;
        req0 = 1'b1; a0 = 16'h1234; b0 = 16'h4321; cin0 = 1'b0;
        req1 = 1'b1; a1 = 16'h7FFF; b1 = 16'h0001; cin1 = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("rr_rst_no_gnt", {30'b0, gnt1, gnt0}, 32'd0);
        rst = 1'b0;
        n = 0;
        for (int i = 0; i < 40 && n < 4; i++) begin
            #1;
            if (gnt0 || gnt1) begin
                ids[n]  = gnt1 ? 1 : 0;
                gcyc[n] = cyc;
                n++;
            end
            @(negedge clk);
        end
        req0 = 1'b0;
        req1 = 1'b0;
        checkOutput("rr_count", n, 32'd4);
        for (int k = 0; k < n; k++) begin
            checkOutput("rr_order", ids[k], k % 2);
            if (k > 0) checkOutput("rr_spacing", gcyc[k] - gcyc[k-1], 32'd6);
        end
        repeat (8) @(negedge clk);

        // Reset in the second ADD cycle abandons the transaction.
        req0 = 1'b1; a0 = 16'h1111; b0 = 16'h2222; cin0 = 1'b0;
        #1;
        checkOutput("abort_gnt", {30'b0, gnt1, gnt0}, 32'd1);
        @(negedge clk);
        req0 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("abort_busy", {31'b0, busy}, 32'd0);
        checkOutput("abort_sum", {16'b0, sum}, 32'd0);
        rst = 1'b0;
        done_seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            if (done) done_seen = 1'b1;
        end
        checkOutput("abort_no_done", {31'b0, done_seen}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
